// File: rtl/palm_locator.sv
`default_nettype none
// ============================================================================
// Module   : palm_locator
// Purpose  : Streams a binary foreground image in raster order and finds the
//            bounding box of the rows that hold enough foreground pixels.
//            The box is published at end of frame and held for a full frame.
//            A palm_width of 0 means that no palm was found.
// Ports    : clk             pixel clock
//            rst             asynchronous active-low reset
//            de_t            pixel valid, one pixel consumed per cycle
//            object_image    foreground pixel (1 = hand)
//            start_of_palm_r/c, end_of_palm_r/c  published box corners
//            palm_width      end_c - start_c + 1, 0 when no palm
//            palm_height     end_r - start_r + 1, 0 when no palm
//            palm_found      published box is valid
//            frame_done      one-cycle pulse when the outputs update
// Revision : 1.0  initial release
// ============================================================================
module palm_locator #(
  parameter int IMAGE_WIDTH  = 120,
  parameter int IMAGE_HEIGHT = 160,
  parameter int ROW_THRESH   = 4,
  parameter int MIN_ROWS     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de_t,
  input  logic       object_image,
  output logic [9:0] start_of_palm_r,
  output logic [9:0] start_of_palm_c,
  output logic [9:0] end_of_palm_r,
  output logic [9:0] end_of_palm_c,
  output logic [9:0] palm_width,
  output logic [9:0] palm_height,
  output logic       palm_found,
  output logic       frame_done
);

  localparam logic [9:0] c_col_last   = 10'(IMAGE_WIDTH - 1);
  localparam logic [9:0] c_row_last   = 10'(IMAGE_HEIGHT - 1);
  localparam logic [9:0] c_row_thresh = 10'(ROW_THRESH);
  localparam logic [9:0] c_min_rows   = 10'(MIN_ROWS);
  localparam logic [9:0] c_sat        = 10'h3FF;

  localparam logic [1:0] c_st_scan = 2'd0;
  localparam logic [1:0] c_st_eval = 2'd1;
  localparam logic [1:0] c_st_pub  = 2'd2;

  // scan position
  logic [9:0] col_q, row_q;
  // per-row accumulators
  logic [9:0] row_cnt_q, row_cnt_d;
  logic [9:0] row_min_q, row_min_d;
  logic [9:0] row_max_q, row_max_d;
  // end-of-row snapshot
  logic [9:0] snap_row_q, snap_cnt_q, snap_min_q, snap_max_q;
  logic       snap_last_q;
  // per-frame accumulators
  logic [9:0] box_start_r_q, box_end_r_q, box_min_c_q, box_max_c_q;
  logic [9:0] qual_rows_q;
  // published outputs
  logic [9:0] start_r_q, start_c_q, end_r_q, end_c_q, width_q, height_q;
  logic       found_q, done_q;

  logic [1:0] state_q, state_d;
  logic       w_pix, w_row_end, w_eval, w_publish, w_eval_qual, w_palm_ok;

  assign w_pix       = de_t & object_image;
  assign w_row_end   = de_t && (col_q == c_col_last);
  assign w_eval_qual = w_eval && (snap_cnt_q >= c_row_thresh);
  assign w_palm_ok   = (qual_rows_q >= c_min_rows);

  // Row accumulators including the pixel consumed this cycle, so the last
  // pixel of a row lands in the snapshot. A zero count marks an empty row,
  // which lets the first foreground pixel seed both min and max.
  always_comb begin
    row_cnt_d = row_cnt_q;
    row_min_d = row_min_q;
    row_max_d = row_max_q;
    if (w_pix) begin
      if (row_cnt_q != c_sat) row_cnt_d = row_cnt_q + 10'd1;
      if ((row_cnt_q == '0) || (col_q < row_min_q)) row_min_d = col_q;
      if ((row_cnt_q == '0) || (col_q > row_max_q)) row_max_d = col_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (de_t) begin
      if (col_q == c_col_last) begin
        col_q <= '0;
        row_q <= (row_q == c_row_last) ? '0 : row_q + 10'd1;
      end else begin
        col_q <= col_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt_q   <= '0;
      row_min_q   <= '0;
      row_max_q   <= '0;
      snap_row_q  <= '0;
      snap_cnt_q  <= '0;
      snap_min_q  <= '0;
      snap_max_q  <= '0;
      snap_last_q <= 1'b0;
    end else if (w_row_end) begin
      snap_row_q  <= row_q;
      snap_cnt_q  <= row_cnt_d;
      snap_min_q  <= row_min_d;
      snap_max_q  <= row_max_d;
      snap_last_q <= (row_q == c_row_last);
      row_cnt_q   <= '0;
      row_min_q   <= '0;
      row_max_q   <= '0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      row_min_q   <= row_min_d;
      row_max_q   <= row_max_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= c_st_scan;
    else      state_q <= state_d;
  end

  // FSM: next state. The snapshot and the move to ROW_EVAL share one edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_scan: if (w_row_end) state_d = c_st_eval;
      c_st_eval: state_d = snap_last_q ? c_st_pub : c_st_scan;
      c_st_pub:  state_d = c_st_scan;
      default:   state_d = c_st_scan;
    endcase
  end

  // FSM: state decode
  always_comb begin
    w_eval    = (state_q == c_st_eval);
    w_publish = (state_q == c_st_pub);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_start_r_q <= '0;
      box_end_r_q   <= '0;
      box_min_c_q   <= '0;
      box_max_c_q   <= '0;
      qual_rows_q   <= '0;
    end else if (w_publish) begin
      box_start_r_q <= '0;
      box_end_r_q   <= '0;
      box_min_c_q   <= '0;
      box_max_c_q   <= '0;
      qual_rows_q   <= '0;
    end else if (w_eval_qual) begin
      if (qual_rows_q == '0) begin
        box_start_r_q <= snap_row_q;
        box_min_c_q   <= snap_min_q;
        box_max_c_q   <= snap_max_q;
      end else begin
        if (snap_min_q < box_min_c_q) box_min_c_q <= snap_min_q;
        if (snap_max_q > box_max_c_q) box_max_c_q <= snap_max_q;
      end
      box_end_r_q <= snap_row_q;
      if (qual_rows_q != c_sat) qual_rows_q <= qual_rows_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r_q <= '0;
      start_c_q <= '0;
      end_r_q   <= '0;
      end_c_q   <= '0;
      width_q   <= '0;
      height_q  <= '0;
      found_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= w_publish;
      if (w_publish) begin
        if (w_palm_ok) begin
          start_r_q <= box_start_r_q;
          start_c_q <= box_min_c_q;
          end_r_q   <= box_end_r_q;
          end_c_q   <= box_max_c_q;
          width_q   <= box_max_c_q - box_min_c_q + 10'd1;
          height_q  <= box_end_r_q - box_start_r_q + 10'd1;
          found_q   <= 1'b1;
        end else begin
          start_r_q <= '0;
          start_c_q <= '0;
          end_r_q   <= '0;
          end_c_q   <= '0;
          width_q   <= '0;
          height_q  <= '0;
          found_q   <= 1'b0;
        end
      end
    end
  end

  assign start_of_palm_r = start_r_q;
  assign start_of_palm_c = start_c_q;
  assign end_of_palm_r   = end_r_q;
  assign end_of_palm_c   = end_c_q;
  assign palm_width      = width_q;
  assign palm_height     = height_q;
  assign palm_found      = found_q;
  assign frame_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_palm_locator.sv
`default_nettype none
// ============================================================================
// Module   : tb_palm_locator
// Purpose  : Self-checking bench for palm_locator. Frames are built in an
//            image array, streamed in raster order, and the published box is
//            compared with a reference computed directly from the image.
//            The frame height is reduced to keep run time short.
// Revision : 1.0  initial release
// ============================================================================
module tb_palm_locator;

  localparam int W    = 120;
  localparam int H    = 32;
  localparam int THR  = 4;
  localparam int MINR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       de_t = 1'b0;
  logic       object_image = 1'b0;
  logic [9:0] sr, sc, er, ec, pw, ph;
  logic       pf, fd;
  logic [60:0] act_v;

  palm_locator #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .ROW_THRESH  (THR),
    .MIN_ROWS    (MINR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .de_t           (de_t),
    .object_image   (object_image),
    .start_of_palm_r(sr),
    .start_of_palm_c(sc),
    .end_of_palm_r  (er),
    .end_of_palm_c  (ec),
    .palm_width     (pw),
    .palm_height    (ph),
    .palm_found     (pf),
    .frame_done     (fd)
  );

  always #5 clk = ~clk;

  assign act_v = {sr, sc, er, ec, pw, ph, pf};

  typedef struct {
    int          cyc;
    logic [60:0] v;
  } ev_t;

  ev_t         evq[$];
  bit          img [0:H-1][0:W-1];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          stab_err = 0;
  int          pulse_err = 0;
  int          last_cyc = 0;
  logic [60:0] prev_v = '0;
  logic        prev_fd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every frame_done pulse, and flags outputs that move outside a
  // pulse or pulses longer than one cycle.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (fd === 1'b1) evq.push_back('{cyc, act_v});
      if (fd === 1'b1 && prev_fd) pulse_err++;
      if (fd !== 1'b1 && act_v !== prev_v) stab_err++;
    end
    prev_v  = act_v;
    prev_fd = (fd === 1'b1);
  end

  // Reference: box of all rows with at least THR foreground pixels.
  function automatic logic [60:0] model();
    int qual, r0, r1, mn, mx, cnt, rmn, rmx;
    qual = 0; r0 = 0; r1 = 0; mn = 0; mx = 0;
    for (int r = 0; r < H; r++) begin
      cnt = 0; rmn = W; rmx = -1;
      for (int c = 0; c < W; c++) begin
        if (img[r][c]) begin
          cnt++;
          if (c < rmn) rmn = c;
          if (c > rmx) rmx = c;
        end
      end
      if (cnt >= THR) begin
        if (qual == 0) begin
          r0 = r; mn = rmn; mx = rmx;
        end else begin
          if (rmn < mn) mn = rmn;
          if (rmx > mx) mx = rmx;
        end
        r1 = r;
        qual++;
      end
    end
    if (qual >= MINR)
      return {10'(r0), 10'(mn), 10'(r1), 10'(mx), 10'(mx - mn + 1), 10'(r1 - r0 + 1), 1'b1};
    return '0;
  endfunction

  task automatic clear_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 1'b0;
  endtask

  task automatic fill_rect(input int r0, input int r1, input int c0, input int c1);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++)
        img[r][c] = 1'b1;
  endtask

  // Streams the first nrows rows; random idle gaps carry junk on object_image.
  task automatic send_frame(input int nrows, input int max_gap);
    int g;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < W; c++) begin
        g = int'($urandom_range(max_gap, 0));
        repeat (g) begin
          @(negedge clk);
          de_t = 1'b0;
          object_image = 1'($urandom);
        end
        @(negedge clk);
        de_t = 1'b1;
        object_image = img[r][c];
        last_cyc = cyc + 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    de_t = 1'b0;
    object_image = 1'b0;
  endtask

  task automatic wait_events(input int n, output bit got);
    for (int i = 0; i < 64 && evq.size() < n; i++) @(negedge clk);
    got = (evq.size() >= n);
  endtask

  task automatic run_frame(input int max_gap, output bit got, output ev_t e, output int lc);
    send_frame(H, max_gap);
    lc = last_cyc;
    idle();
    wait_events(1, got);
    if (got) e = evq.pop_front();
    else     e = '{0, '0};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (act_v !== '0 || fd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: actual=%h/%b required=0/0", act_v, fd);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (fd !== 1'b0 || evq.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle_done: actual fd=%b pulses=%0d required 0/0", fd, evq.size());
    end
  endtask

  task automatic test_rectangle();
    bit got; ev_t e; int lc; logic [60:0] exp;
    clear_img();
    fill_rect(8, 23, 30, 69);
    exp = {10'd8, 10'd30, 10'd23, 10'd69, 10'd40, 10'd16, 1'b1};
    run_frame(0, got, e, lc);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL rect_done: no frame_done pulse, required 1"); end
    n_cmp++;
    if (e.cyc !== lc + 2) begin n_fail++; $display("FAIL rect_latency: actual cyc=%0d required=%0d", e.cyc, lc + 2); end
    n_cmp++;
    if (e.v !== exp) begin n_fail++; $display("FAIL rect_box: actual=%h required=%h", e.v, exp); end
    @(negedge clk);
    n_cmp++;
    if (fd !== 1'b0 || act_v !== exp) begin
      n_fail++;
      $display("FAIL rect_hold: actual fd=%b box=%h required fd=0 box=%h", fd, act_v, exp);
    end
  endtask

  task automatic test_mid_reset();
    bit got; ev_t e; int lc; logic [60:0] exp;
    clear_img();
    fill_rect(8, 23, 30, 69);
    send_frame(17, 0);
    @(negedge clk);
    de_t = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (act_v !== '0 || fd !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: actual=%h/%b required=0/0", act_v, fd);
    end
    n_cmp++;
    if (evq.size() != 0) begin n_fail++; $display("FAIL midrst_no_pulse: actual pulses=%0d required=0", evq.size()); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_img();
    fill_rect(25, H - 1, 0, W - 1);
    exp = {10'd25, 10'd0, 10'd31, 10'd119, 10'd120, 10'd7, 1'b1};
    run_frame(0, got, e, lc);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL midrst_done: no frame_done pulse, required 1"); end
    n_cmp++;
    if (e.cyc !== lc + 2) begin n_fail++; $display("FAIL midrst_latency: actual cyc=%0d required=%0d", e.cyc, lc + 2); end
    n_cmp++;
    if (e.v !== exp) begin n_fail++; $display("FAIL midrst_box: actual=%h required=%h", e.v, exp); end
  endtask

  task automatic test_empty();
    bit got; ev_t e; int lc;
    clear_img();
    run_frame(0, got, e, lc);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL empty_done: no frame_done pulse, required 1"); end
    n_cmp++;
    if (e.cyc !== lc + 2) begin n_fail++; $display("FAIL empty_latency: actual cyc=%0d required=%0d", e.cyc, lc + 2); end
    n_cmp++;
    if (e.v !== '0) begin n_fail++; $display("FAIL empty_box: actual=%h required=0", e.v); end
  endtask

  task automatic test_low_qual();
    bit got; ev_t e; int lc;
    clear_img();
    fill_rect(2, 3, 0, W - 1);
    fill_rect(12, 27, 5, 7);
    run_frame(0, got, e, lc);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL lowq_done: no frame_done pulse, required 1"); end
    n_cmp++;
    if (e.v !== '0) begin n_fail++; $display("FAIL lowq_box: actual=%h required=0", e.v); end
  endtask

  task automatic test_irregular();
    bit got; ev_t e; int lc; logic [60:0] exp;
    clear_img();
    fill_rect(20, 20, 40, 45);
    fill_rect(21, 21, 20, 25);
    fill_rect(22, 22, 50, 60);
    exp = {10'd20, 10'd20, 10'd22, 10'd60, 10'd41, 10'd3, 1'b1};
    run_frame(0, got, e, lc);
    n_cmp++;
    if (!got) begin n_fail++; $display("FAIL irreg_done: no frame_done pulse, required 1"); end
    n_cmp++;
    if (e.v !== exp) begin n_fail++; $display("FAIL irreg_box: actual=%h required=%h", e.v, exp); end
  endtask

  task automatic test_back_to_back();
    bit got; ev_t e1, e2; int lc1, lc2; logic [60:0] exp1, exp2;
    clear_img();
    fill_rect(8, 23, 30, 69);
    exp1 = model();
    send_frame(H, 5);
    lc1 = last_cyc;
    clear_img();
    exp2 = model();
    send_frame(H, 5);
    lc2 = last_cyc;
    idle();
    wait_events(2, got);
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL b2b_done: actual pulses=%0d required=2", evq.size());
    end else begin
      e1 = evq.pop_front();
      e2 = evq.pop_front();
      n_cmp++;
      if (e1.cyc !== lc1 + 2 || e2.cyc !== lc2 + 2) begin
        n_fail++;
        $display("FAIL b2b_latency: actual cyc=%0d,%0d required=%0d,%0d", e1.cyc, e2.cyc, lc1 + 2, lc2 + 2);
      end
      n_cmp++;
      if (e1.v !== exp1) begin n_fail++; $display("FAIL b2b_box1: actual=%h required=%h", e1.v, exp1); end
      n_cmp++;
      if (e2.v !== exp2) begin n_fail++; $display("FAIL b2b_box2: actual=%h required=%h", e2.v, exp2); end
    end
    n_cmp++;
    if (stab_err != 0 || pulse_err != 0) begin
      n_fail++;
      $display("FAIL output_stability: actual changes=%0d long_pulses=%0d required 0/0", stab_err, pulse_err);
    end
  endtask

  task automatic test_random();
    bit got; ev_t e; logic [60:0] exp [3]; int lc [3]; int p;
    for (int f = 0; f < 3; f++) begin
      clear_img();
      for (int r = 0; r < H; r++) begin
        case ($urandom_range(4, 0))
          0:       p = 0;
          1:       p = 3;
          2:       p = 30;
          3:       p = 90;
          default: p = -1;
        endcase
        if (p < 0) begin
          for (int k = 0; k < THR; k++) img[r][$urandom_range(W - 1, 0)] = 1'b1;
        end else begin
          for (int c = 0; c < W; c++) img[r][c] = (int'($urandom_range(99, 0)) < p);
        end
      end
      exp[f] = model();
      send_frame(H, 1);
      lc[f] = last_cyc;
    end
    idle();
    wait_events(3, got);
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL rand_done: actual pulses=%0d required=3", evq.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        e = evq.pop_front();
        n_cmp++;
        if (e.cyc !== lc[f] + 2) begin
          n_fail++;
          $display("FAIL rand_latency[%0d]: actual cyc=%0d required=%0d", f, e.cyc, lc[f] + 2);
        end
        n_cmp++;
        if (e.v !== exp[f]) begin n_fail++; $display("FAIL rand_box[%0d]: actual=%h required=%h", f, e.v, exp[f]); end
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rectangle();
    test_mid_reset();
    test_empty();
    test_low_qual();
    test_irregular();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/palm_locator.md
Name: palm_locator

Overview:
Streaming producer of the palm bounding box consumed by the finger-identification stage. It scans the binary foreground pixel stream in raster order and qualifies rows that contain enough foreground pixels. At end of frame it publishes start/end row/column, palm_width and palm_height, registered and held for the whole next frame. palm_width==0 is the "no palm" encoding the downstream stage relies on.

Parameters:
IMAGE_WIDTH, 120, pixels per row
IMAGE_HEIGHT, 160, rows per frame
ROW_THRESH, 4, minimum foreground pixels for a row to qualify as palm
MIN_ROWS, 3, minimum qualifying rows in a frame to declare a palm

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
de_t  in  1  pixel valid; one pixel consumed per cycle when high
object_image  in  1  foreground pixel (1 = hand)
start_of_palm_r  out  10  top qualifying row
start_of_palm_c  out  10  leftmost foreground column within qualifying rows
end_of_palm_r  out  10  bottom qualifying row
end_of_palm_c  out  10  rightmost foreground column within qualifying rows
palm_width  out  10  end_c - start_c + 1, or 0 if no palm
palm_height  out  10  end_r - start_r + 1, or 0 if no palm
palm_found  out  1  high while the published box is valid
frame_done  out  1  one-cycle pulse when outputs are updated

Behaviour:
- Reset (rst low, async): all outputs 0; row/col counters 0; all row and frame accumulators cleared; FSM to SCAN.
- Counters advance only on de_t. col wraps at IMAGE_WIDTH-1 to 0 and increments row. row wraps at IMAGE_HEIGHT-1 to 0. De-asserted de_t gaps of any length freeze all scan state.
- Row accumulators: row_cnt (10 b, saturating at 1023), row_min_c, row_max_c. They are updated on each valid pixel with object_image=1. The last pixel of a row is included.
- At the last pixel of a row, a snapshot (row index, row_cnt, min, max, last-row flag) is registered and the row accumulators clear in that same cycle. A pixel arriving on the next cycle belongs to the new row. There is no stall and no lost pixel.
- FSM:
  - SCAN: on a snapshot, go to ROW_EVAL.
  - ROW_EVAL, one cycle: if row_cnt >= ROW_THRESH, update the frame box:
    - first qualifying row sets start_r; every qualifying row sets end_r;
    - box_min_c = min(box_min_c, row_min_c); box_max_c = max(box_max_c, row_max_c);
    - qual_rows increments, saturating.
    - Then go to PUBLISH if the last-row flag is set, else to SCAN.
    - A pixel arriving during ROW_EVAL is accumulated normally. The next snapshot cannot occur within 1 cycle because IMAGE_WIDTH >= 2.
  - PUBLISH, one cycle:
    - If qual_rows >= MIN_ROWS, drive box outputs, width and height, and set palm_found=1.
    - Otherwise drive all box outputs, width and height to 0 and set palm_found=0.
    - Pulse frame_done, clear the frame accumulators, return to SCAN.
- Latency: outputs and frame_done appear 2 clk edges after the edge that consumes the final pixel (row IMAGE_HEIGHT-1, col IMAGE_WIDTH-1).
- Outputs are stable between PUBLISH cycles. They change only in PUBLISH or on reset.
- Arithmetic: all widths are 10 b unsigned. Width and height are computed from the registered box. end >= start is guaranteed by construction.
- A qualifying row with a single foreground span narrower than the existing box never shrinks the box.
- If rst is asserted mid-frame, the partial frame is discarded and the previous published box is cleared to 0. Scanning restarts at row 0, col 0 on the first de_t after release.

Test Plan:
- Solid rectangle, rows 50..89 and cols 30..69 set, rest 0, continuous de_t -> frame_done pulse 2 cycles after pixel (159,119); start_r=50, end_r=89, start_c=30, end_c=69, palm_width=40, palm_height=40, palm_found=1.
- All-zero frame -> frame_done pulse; all box outputs 0; palm_found=0.
- Rows 10..11 full (qual_rows=2 < MIN_ROWS), plus rows 100..139 with only 3 pixels each at cols 5..7 -> no palm; outputs 0.
- Irregular hand: row 60 with cols 40..45, row 61 with cols 20..25, row 62 with cols 50..60 -> start_c=20, end_c=60, width=41, start_r=60, end_r=62, height=3.
- Frame 1 rectangle followed by an all-zero frame 2, with random de_t gaps of 0..5 cycles -> box held through frame 2, cleared at frame 2 PUBLISH; results identical to gap-free run.
- rst low at row 80 of a rectangle frame, released and a fresh frame sent -> outputs 0 immediately on reset; the new frame's box alone is published.
